// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect types: write-channel FSM encoding, AXI field widths and response codes.
// Imported by the write-path controller and its beat counter.
package axi_ic_pkg;

   localparam logic [1:0] WC_IDLE = 2'd0;
   localparam logic [1:0] WC_ADDR = 2'd1;
   localparam logic [1:0] WC_DATA = 2'd2;
   localparam logic [1:0] WC_RESP = 2'd3;

   localparam int AXI_LEN_W  = 8;
   localparam int AXI_RESP_W = 2;

   localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = WC_IDLE,
      ST_ADDR = WC_ADDR,
      ST_DATA = WC_DATA,
      ST_RESP = WC_RESP
   } wc_state_t;

endpackage

// File: rtl/write_beat_counter.sv
// Remaining-beat counter for one write burst: loaded with awlen, decremented per W beat.
// is_last is high while the current beat is the final one the AW phase announced.
module write_beat_counter
   import axi_ic_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [AXI_LEN_W-1:0] load_val,
   input  logic                 dec,
   output logic                 is_last
);

   logic [AXI_LEN_W-1:0] count;

   // Saturate at zero so a 256-beat burst never wraps back to 255.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign is_last = (count == '0);

endmodule

// File: rtl/axi_write_channel_ctrl.sv
// Owns the shared master write channel for one AW/W/B burst on behalf of the arbiter's winner.
// Handshakes pass through combinationally; the arbiter's winner is frozen while Token is high.
module axi_write_channel_ctrl
   import axi_ic_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
)
(
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    Channel_Request,
   input  logic                    Arb_Select,
   output logic                    Channel_Granted,
   output logic                    Token,
   output logic                    Burst_Error,

   input  logic [ADDR_WIDTH-1:0]   S00_AXI_awaddr,
   input  logic [AXI_LEN_W-1:0]    S00_AXI_awlen,
   input  logic                    S00_AXI_awvalid,
   output logic                    S00_AXI_awready,
   input  logic [DATA_WIDTH-1:0]   S00_AXI_wdata,
   input  logic [DATA_WIDTH/8-1:0] S00_AXI_wstrb,
   input  logic                    S00_AXI_wlast,
   input  logic                    S00_AXI_wvalid,
   output logic                    S00_AXI_wready,
   output logic [AXI_RESP_W-1:0]   S00_AXI_bresp,
   output logic                    S00_AXI_bvalid,
   input  logic                    S00_AXI_bready,

   input  logic [ADDR_WIDTH-1:0]   S01_AXI_awaddr,
   input  logic [AXI_LEN_W-1:0]    S01_AXI_awlen,
   input  logic                    S01_AXI_awvalid,
   output logic                    S01_AXI_awready,
   input  logic [DATA_WIDTH-1:0]   S01_AXI_wdata,
   input  logic [DATA_WIDTH/8-1:0] S01_AXI_wstrb,
   input  logic                    S01_AXI_wlast,
   input  logic                    S01_AXI_wvalid,
   output logic                    S01_AXI_wready,
   output logic [AXI_RESP_W-1:0]   S01_AXI_bresp,
   output logic                    S01_AXI_bvalid,
   input  logic                    S01_AXI_bready,

   output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
   output logic [AXI_LEN_W-1:0]    M_AXI_awlen,
   output logic                    M_AXI_awvalid,
   input  logic                    M_AXI_awready,
   output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
   output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
   output logic                    M_AXI_wlast,
   output logic                    M_AXI_wvalid,
   input  logic                    M_AXI_wready,
   input  logic [AXI_RESP_W-1:0]   M_AXI_bresp,
   input  logic                    M_AXI_bvalid,
   output logic                    M_AXI_bready
);

   wc_state_t state;

   logic in_addr, in_data, in_resp;
   logic own;
   logic own_awvalid, own_wvalid, own_wlast, own_bready;
   logic aw_hs, w_hs, b_hs;
   logic cnt_last, term_beat;

   assign own     = Arb_Select;
   assign in_addr = (state == ST_ADDR);
   assign in_data = (state == ST_DATA);
   assign in_resp = (state == ST_RESP);

   assign own_awvalid = own ? S01_AXI_awvalid : S00_AXI_awvalid;
   assign own_wvalid  = own ? S01_AXI_wvalid  : S00_AXI_wvalid;
   assign own_wlast   = own ? S01_AXI_wlast   : S00_AXI_wlast;
   assign own_bready  = own ? S01_AXI_bready  : S00_AXI_bready;

   // Payload follows the owner in every state; only the valids are state-gated.
   assign M_AXI_awaddr  = own ? S01_AXI_awaddr : S00_AXI_awaddr;
   assign M_AXI_awlen   = own ? S01_AXI_awlen  : S00_AXI_awlen;
   assign M_AXI_wdata   = own ? S01_AXI_wdata  : S00_AXI_wdata;
   assign M_AXI_wstrb   = own ? S01_AXI_wstrb  : S00_AXI_wstrb;
   assign M_AXI_wlast   = cnt_last;

   assign M_AXI_awvalid = in_addr && own_awvalid;
   assign M_AXI_wvalid  = in_data && own_wvalid;
   assign M_AXI_bready  = in_resp && own_bready;

   assign S00_AXI_awready = in_addr && !own && M_AXI_awready;
   assign S01_AXI_awready = in_addr &&  own && M_AXI_awready;
   assign S00_AXI_wready  = in_data && !own && M_AXI_wready;
   assign S01_AXI_wready  = in_data &&  own && M_AXI_wready;
   assign S00_AXI_bvalid  = in_resp && !own && M_AXI_bvalid;
   assign S01_AXI_bvalid  = in_resp &&  own && M_AXI_bvalid;
   assign S00_AXI_bresp   = own ? AXI_RESP_OKAY : M_AXI_bresp;
   assign S01_AXI_bresp   = own ? M_AXI_bresp   : AXI_RESP_OKAY;

   assign aw_hs     = M_AXI_awvalid && M_AXI_awready;
   assign w_hs      = M_AXI_wvalid && M_AXI_wready;
   assign b_hs      = M_AXI_bvalid && M_AXI_bready;
   // Either the announced length or the master's wlast ends the burst, whichever comes first.
   assign term_beat = w_hs && (cnt_last || own_wlast);

   assign Channel_Granted = (state == ST_IDLE);
   assign Token           = (state != ST_IDLE);

   write_beat_counter u_beat_cnt (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .load     (aw_hs),
      .load_val (M_AXI_awlen),
      .dec      (w_hs),
      .is_last  (cnt_last)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state       <= ST_IDLE;
         Burst_Error <= 1'b0;
      end else begin
         Burst_Error <= 1'b0;
         case (state)
            ST_IDLE: if (Channel_Request) state <= ST_ADDR;
            ST_ADDR: if (aw_hs)           state <= ST_DATA;
            ST_DATA: begin
               if (term_beat) begin
                  state       <= ST_RESP;
                  Burst_Error <= (own_wlast != cnt_last);
               end
            end
            ST_RESP: if (b_hs)            state <= ST_IDLE;
            default:                      state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/axi_write_channel_ctrl.md
# axi_write_channel_ctrl

Write-path controller that sits directly downstream of the two-master QoS write-address arbiter in the AXI interconnect. It accepts the arbiter's request and registered winner index and owns the shared master-side write channel for one full burst (AW, then W, then B). It routes handshakes between the winning slave port (S00/S01) and the single downstream M port. It returns `Channel_Granted`/`Token` to the arbiter so the winner stays frozen until the B response completes.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AW address width.
- `DATA_WIDTH`, 32: W data width; `wstrb` width is `DATA_WIDTH/8`.

Ports (x ∈ {0,1}; `S0x_*` exists for S00 and S01):
- `ACLK` in 1: single clock, rising edge.
- `ARESETN` in 1: asynchronous, active-low reset.
- `Channel_Request` in 1: request from arbiter.
- `Arb_Select` in 1: arbiter's registered winner (0=S00, 1=S01).
- `Channel_Granted` out 1: channel idle; arbiter may sample/update winner.
- `Token` out 1: burst in flight; arbiter winner frozen.
- `Burst_Error` out 1: one-cycle pulse on AWLEN/WLAST mismatch.
- `S0x_AXI_awaddr` in ADDR_WIDTH, `S0x_AXI_awlen` in 8, `S0x_AXI_awvalid` in 1, `S0x_AXI_awready` out 1.
- `S0x_AXI_wdata` in DATA_WIDTH, `S0x_AXI_wstrb` in DATA_WIDTH/8, `S0x_AXI_wlast` in 1, `S0x_AXI_wvalid` in 1, `S0x_AXI_wready` out 1.
- `S0x_AXI_bresp` out 2, `S0x_AXI_bvalid` out 1, `S0x_AXI_bready` in 1.
- `M_AXI_awaddr` out ADDR_WIDTH, `M_AXI_awlen` out 8, `M_AXI_awvalid` out 1, `M_AXI_awready` in 1.
- `M_AXI_wdata` out DATA_WIDTH, `M_AXI_wstrb` out DATA_WIDTH/8, `M_AXI_wlast` out 1, `M_AXI_wvalid` out 1, `M_AXI_wready` in 1.
- `M_AXI_bresp` in 2, `M_AXI_bvalid` in 1, `M_AXI_bready` out 1.

## Operation
- FSM states and transitions:
  - IDLE → ADDR on `Channel_Request`.
  - ADDR → DATA on M AW handshake.
  - DATA → RESP on the terminating W handshake.
  - RESP → IDLE on M B handshake.
- `Channel_Granted` = (state==IDLE); `Token` = (state!=IDLE). Both are decoded directly from the state register.
- Owner = `Arb_Select`. It is valid from the first ADDR cycle, and the arbiter holds it stable while `Token`=1.
- ADDR:
  - M AW fields and `M_AXI_awvalid` are muxed from the owner.
  - `M_AXI_awready` is routed to the owner only.
  - On handshake, load beat counter with the owner's `awlen`.
- DATA:
  - W fields and `wvalid` are muxed from the owner; `M_AXI_wready` goes to the owner's `wready`.
  - Each W handshake decrements the counter.
  - The terminating beat is a handshake with counter==0 or `wlast`==1.
  - If `wlast` and counter==0 disagree on the terminating beat, pulse `Burst_Error`. The transition to RESP happens regardless.
  - `M_AXI_wlast` is driven as (counter==0), never passed through.
- RESP:
  - `M_AXI_bvalid`/`bresp` are routed to the owner; owner `bready` drives `M_AXI_bready`.
  - The non-owner's `bresp` is driven 2'b00.
- Non-owner port always sees `awready`=`wready`=`bvalid`=0.
- Outside their state:
  - All M valid and S ready outputs are 0 except in their owning state.
  - `M_AXI_bready`=0 outside RESP.
  - W is never accepted before AW completes.
- Payload outputs (addr/len/data/strb) follow the owner mux in every state; they are only meaningful when the matching valid is high.

## Timing
- Reset (`ARESETN` low, any state, including mid-burst):
  - Immediately: state=IDLE, counter=0.
  - Resulting outputs: `Token`=0, `Channel_Granted`=1, `Burst_Error`=0, all valids/readys 0.
  - An in-flight burst is abandoned; no B is generated.
- `Channel_Request` sampled high in IDLE at edge N: ADDR at N+1, and `M_AXI_awvalid` at N+1 if the owner's `awvalid` is high.
- Pass-through latency: valid/ready paths are combinational in their state; no pipeline registers on payload.
- Minimum single-beat burst: 4 cycles (IDLE, ADDR, DATA, RESP). The next burst can request in the IDLE cycle after RESP.
- `awlen`=255: 256 beats; the 8-bit counter must not wrap before termination.
- AW handshake in ADDR and W valid in the same cycle: W is not accepted until DATA.

## Structure
- Shared package `axi_ic_pkg`:
  - state localparams `WC_IDLE=2'd0`, `WC_ADDR=2'd1`, `WC_DATA=2'd2`, `WC_RESP=2'd3`;
  - `AXI_LEN_W=8`, `AXI_RESP_W=2`;
  - `AXI_RESP_OKAY=2'b00`.
- Sub-module `write_beat_counter`: 8-bit counter with load, decrement, and is-last outputs. The top level holds the FSM and the muxes.

## Test plan
- S00 only, `awlen`=0, addr 0x1000, data 0xDEADBEEF, `bresp`=OKAY → M sees the AW then one W with `wlast`=1. S00 gets OKAY. `Token` is high for 3 cycles, then `Channel_Granted`=1.
- `Arb_Select`=1, `awlen`=3, M `wready` toggled 1/0 → exactly 4 beats forwarded; `M_AXI_wlast` only on the 4th; S00 `wready` stays 0.
- `awlen`=3 with S01 asserting `wlast` on beat 2 → transition to RESP after beat 2; `Burst_Error` pulses for 1 cycle.
- `awlen`=1 with no `wlast` on beat 2 → terminate after beat 2; `Burst_Error` pulses.
- `ARESETN` low mid-DATA (beat 2 of 4) → next cycle all valids are 0, `Token`=0, state IDLE. A new burst after reset completes normally.
- Back-to-back: S00 then S01, `awlen`=0 each → the second AW appears on M in the cycle after the first B handshake plus one IDLE cycle.
